// File: rtl/crc8_frame_serializer.sv
// Buffers FRAME_BYTES bytes, streams them MSB-first into an external negedge CRC-8 stage, returns its result.
// Define CRC8_SER_SELFCHECK_EN for a shadow CRC that flags crc_err when the stage's result disagrees.
module crc8_frame_serializer #(
  parameter  int FRAME_BYTES = 4,
  localparam int IDX_W       = (FRAME_BYTES > 1) ? $clog2(FRAME_BYTES) : 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       ser_bit,
  output logic       crc_run,
  input  logic [7:0] crc_in,
  output logic [7:0] frame_crc,
  output logic       crc_valid,
  input  logic       crc_ready,
`ifdef CRC8_SER_SELFCHECK_EN
  output logic       crc_err,
`endif
  output logic       busy
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_BYTES - 1);

  typedef enum logic [1:0] {S_COLLECT, S_SHIFT, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_cnt;
  logic [2:0]       r_bit;
  logic             r_ser;
  logic [7:0]       r_frame_crc;
  logic [7:0]       r_buf [2**IDX_W];

  logic             w_accept;
  logic             w_last_bit;
  logic [IDX_W-1:0] w_cnt_nxt;
  logic [2:0]       w_bit_nxt;
  logic             w_first_bit;
  logic             w_next_bit;

  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    crc_run     = 1'b0;
    crc_valid   = 1'b0;
    busy        = 1'b0;
    w_accept    = 1'b0;
    w_last_bit  = 1'b0;
    case (r_state)
      S_COLLECT: begin
        in_ready = 1'b1;
        w_accept = in_valid;
        if (in_valid && (r_cnt == LAST_IDX)) w_state_nxt = S_SHIFT;
      end
      S_SHIFT: begin
        crc_run    = 1'b1;
        busy       = 1'b1;
        w_last_bit = (r_cnt == LAST_IDX) && (r_bit == 3'd0);
        if (w_last_bit) w_state_nxt = S_DONE;
      end
      S_DONE: begin
        crc_valid = 1'b1;
        busy      = 1'b1;
        if (crc_ready) w_state_nxt = S_COLLECT;
      end
      default: w_state_nxt = S_COLLECT;
    endcase
  end

  // The last byte of a single-byte frame is still on in_data when SHIFT starts.
  assign w_first_bit = (r_cnt == '0) ? in_data[7] : r_buf[0][7];
  assign w_bit_nxt   = r_bit - 3'd1;
  assign w_cnt_nxt   = r_cnt + IDX_W'(r_bit == 3'd0);
  assign w_next_bit  = r_buf[w_cnt_nxt][w_bit_nxt];

  always_ff @(posedge clk) begin
    if (w_accept) r_buf[r_cnt] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_COLLECT;
      r_cnt       <= '0;
      r_bit       <= 3'd0;
      r_ser       <= 1'b0;
      r_frame_crc <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_COLLECT: begin
          if (w_accept) begin
            if (r_cnt == LAST_IDX) begin
              r_cnt <= '0;
              r_bit <= 3'd7;
              r_ser <= w_first_bit;
            end else begin
              r_cnt <= r_cnt + IDX_W'(1);
            end
          end
        end
        S_SHIFT: begin
          if (w_last_bit) begin
            r_cnt       <= '0;
            r_ser       <= 1'b0;
            r_frame_crc <= crc_in;
          end else begin
            r_cnt <= w_cnt_nxt;
            r_bit <= w_bit_nxt;
            r_ser <= w_next_bit;
          end
        end
        default: ;
      endcase
    end
  end

  assign ser_bit   = r_ser;
  assign frame_crc = r_frame_crc;

`ifdef CRC8_SER_SELFCHECK_EN
  logic [7:0] r_chk;
  logic [7:0] w_chk_nxt;
  logic       r_err;

  // Same recurrence as the external stage, advanced on posedge from the bit being presented.
  assign w_chk_nxt = {r_chk[6:0], 1'b0} ^ ((r_chk[7] ^ r_ser) ? 8'h07 : 8'h00);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_chk <= 8'h00;
      r_err <= 1'b0;
    end else begin
      case (r_state)
        S_SHIFT: begin
          r_chk <= w_chk_nxt;
          if (w_last_bit) r_err <= (w_chk_nxt != crc_in);
        end
        S_DONE: if (crc_ready) r_err <= 1'b0;
        default: begin
          r_chk <= 8'h00;
          r_err <= 1'b0;
        end
      endcase
    end
  end

  assign crc_err = r_err;
`endif

endmodule

// File: tb/tb_crc8_frame_serializer.sv
// Three serializers (1, 9 and 4 byte frames), each driving its own model of the negedge CRC-8 stage.
module tb_crc8_frame_serializer;
  localparam int N = 3;
  localparam int FB [N] = '{1, 9, 4};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset     [N];
  logic [7:0] in_data   [N];
  logic       in_valid  [N];
  logic       in_ready  [N];
  logic       ser_bit   [N];
  logic       crc_run   [N];
  logic [7:0] crc_in    [N];
  logic [7:0] frame_crc [N];
  logic       crc_valid [N];
  logic       crc_ready [N];
  logic       busy      [N];
`ifdef CRC8_SER_SELFCHECK_EN
  logic       crc_err   [N];
`endif
  logic [7:0] crc_reg   [N];
  logic       flip      [N];

  logic [7:0] sb_q [$];
  int checks   = 0;
  int failures = 0;

  for (genvar g = 0; g < N; g++) begin : g_dut
    crc8_frame_serializer #(.FRAME_BYTES(FB[g])) u_dut (
      .clk       (clk),
      .reset     (reset[g]),
      .in_data   (in_data[g]),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .ser_bit   (ser_bit[g]),
      .crc_run   (crc_run[g]),
      .crc_in    (crc_in[g]),
      .frame_crc (frame_crc[g]),
      .crc_valid (crc_valid[g]),
      .crc_ready (crc_ready[g]),
`ifdef CRC8_SER_SELFCHECK_EN
      .crc_err   (crc_err[g]),
`endif
      .busy      (busy[g])
    );
  end

  function automatic logic [7:0] crc_step(input logic [7:0] r, input logic b);
    return {r[6:0], 1'b0} ^ ((r[7] ^ b) ? 8'h07 : 8'h00);
  endfunction

  function automatic logic [7:0] crc_bytes(input logic [7:0] b [16], input int n);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < n; i++)
      for (int j = 7; j >= 0; j--) r = crc_step(r, b[i][j]);
    return r;
  endfunction

  // External CRC stage: clears while crc_run=0, advances on negedge while crc_run=1.
  always @(negedge clk)
    for (int k = 0; k < N; k++)
      crc_reg[k] <= crc_run[k] ? crc_step(crc_reg[k], ser_bit[k]) : 8'h00;

  always_comb
    for (int k = 0; k < N; k++) crc_in[k] = crc_reg[k] ^ {7'd0, flip[k]};

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input int k, input int n, input logic [7:0] b [16], input int gap_max,
                           input logic [7:0] exp, input int hold, input logic flp, input string tag);
    logic [127:0] got_s;
    logic [127:0] exp_s;
    int nshift;
    int tmo;
    int bad;
    got_s = '0;
    exp_s = '0;
    tmo   = 0;
    bad   = 0;
    flip[k] = flp;
    sb_q.push_back(exp ^ {7'd0, flp});
    for (int i = 0; i < n; i++) begin
      exp_s = {exp_s[119:0], b[i]};
      repeat ($urandom_range(0, gap_max)) begin
        in_valid[k] = 1'b0;
        tick();
      end
      in_valid[k] = 1'b1;
      in_data[k]  = b[i];
      while (in_ready[k] !== 1'b1 && tmo < 50) begin
        tick();
        tmo++;
      end
      tick();
    end
    // With a hold phase, keep offering junk through SHIFT and DONE; it must not be consumed.
    in_valid[k] = (hold > 0);
    in_data[k]  = 8'hAA;
    check({tag, "_accept_timeout"}, tmo, 0);
    nshift = 0;
    while (crc_run[k] === 1'b1 && nshift < 200) begin
      got_s = {got_s[126:0], ser_bit[k]};
      nshift++;
      tick();
    end
    check({tag, "_shift_cycles"}, nshift, 8 * n);
    check({tag, "_ser_stream"}, got_s, exp_s);
    check({tag, "_done_valid"}, crc_valid[k], 1'b1);
    check({tag, "_done_in_ready"}, in_ready[k], 1'b0);
    check({tag, "_done_run"}, crc_run[k], 1'b0);
    check({tag, "_done_busy"}, busy[k], 1'b1);
`ifdef CRC8_SER_SELFCHECK_EN
    check({tag, "_crc_err"}, crc_err[k], flp);
`endif
    if (hold > 0) begin
      crc_ready[k] = 1'b0;
      repeat (hold) begin
        tick();
        if (crc_valid[k] !== 1'b1 || frame_crc[k] !== sb_q[0] || in_ready[k] !== 1'b0 || busy[k] !== 1'b1)
          bad++;
      end
      check({tag, "_hold_stable"}, bad, 0);
    end
    crc_ready[k] = 1'b1;
    in_valid[k]  = 1'b0;
    check({tag, "_frame_crc"}, frame_crc[k], sb_q.pop_front());
    tick();
    check({tag, "_post_valid"}, crc_valid[k], 1'b0);
    check({tag, "_post_in_ready"}, in_ready[k], 1'b1);
    check({tag, "_post_run_low"}, crc_run[k], 1'b0);
    check({tag, "_post_busy"}, busy[k], 1'b0);
    flip[k] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] fr [16];
    for (int i = 0; i < 16; i++) fr[i] = 8'h31 + 8'(i);
    for (int k = 0; k < N; k++) begin
      reset[k] = 1'b1;  in_valid[k] = 1'b0;  in_data[k] = 8'h00;
      crc_ready[k] = 1'b1;  flip[k] = 1'b0;
    end
    tick();
    tick();
    for (int k = 0; k < N; k++) reset[k] = 1'b0;
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst%0d_in_ready", k), in_ready[k], 1'b1);
      check($sformatf("rst%0d_valid", k), crc_valid[k], 1'b0);
      check($sformatf("rst%0d_busy", k), busy[k], 1'b0);
      check($sformatf("rst%0d_run", k), crc_run[k], 1'b0);
      check($sformatf("rst%0d_ser", k), ser_bit[k], 1'b0);
      check($sformatf("rst%0d_crc", k), frame_crc[k], 8'h00);
    end

    // Single-byte frames, including back-to-back 0x00 then 0xFF.
    begin
      logic [7:0] one [16];
      for (int i = 0; i < 16; i++) one[i] = 8'h00;
      one[0] = 8'h01;  run_frame(0, 1, one, 0, 8'h07, 0, 1'b0, "fb1_01");
      one[0] = 8'h00;  run_frame(0, 1, one, 0, 8'h00, 0, 1'b0, "fb1_00");
      one[0] = 8'hFF;  run_frame(0, 1, one, 0, 8'hF3, 0, 1'b0, "fb1_FF");
      // Corrupted stage result: frame_crc follows crc_in, crc_err flags it when enabled.
      one[0] = 8'h5A;  run_frame(0, 1, one, 0, crc_bytes(one, 1), 0, 1'b1, "fb1_flip");
      one[0] = 8'h5A;  run_frame(0, 1, one, 0, crc_bytes(one, 1), 0, 1'b0, "fb1_noflip");
    end

    run_frame(1, 9, fr, 3, 8'hF4, 0, 1'b0, "fb9_gaps");

    run_frame(2, 4, fr, 0, crc_bytes(fr, 4), 10, 1'b0, "fb4_hold");

    // Abort at shift cycle 13 of a 4-byte frame.
    in_valid[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_data[2] = 8'hC0 + 8'(i);
      tick();
    end
    in_valid[2] = 1'b0;
    repeat (13) tick();
    check("abort_in_shift", crc_run[2], 1'b1);
    reset[2] = 1'b1;
    tick();
    reset[2] = 1'b0;
    check("abort_run", crc_run[2], 1'b0);
    check("abort_valid", crc_valid[2], 1'b0);
    check("abort_crc", frame_crc[2], 8'h00);
    check("abort_in_ready", in_ready[2], 1'b1);
    check("abort_busy", busy[2], 1'b0);
    check("abort_ser", ser_bit[2], 1'b0);
    run_frame(2, 4, fr, 1, crc_bytes(fr, 4), 0, 1'b0, "fb4_after_abort");

    check("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
